// File: rtl/regwrite_trace_buffer.sv
// regwrite_trace_buffer
// Snoops the general-register write port of the multicycle datapath and
// records every committed write (address + data) into a FIFO, oldest first,
// for later readout. A watchdog moves the capture FSM to HALTED once the
// datapath has made no register write for TIMEOUT consecutive CAPTURE cycles.
//
// Optional feature macro: REGWRITE_TRACE_TIMESTAMP_EN
//   When defined, every entry also stores a 16-bit free-running cycle stamp,
//   presented on rd_stamp for the head entry.
//
// Ports:
//   CLK           clock, rising edge
//   RST           synchronous, active-high reset
//   arm           pulse: clear the buffer and start capturing (IDLE/HALTED only)
//   GRegWrite     register-file write enable
//   WriteAddress  register-file write address
//   writeDataIn   register-file write data
//   rd_en         pop the head entry (ignored when empty)
//   rd_valid      buffer holds at least one entry
//   rd_addr       head entry address (0 when empty)
//   rd_data       head entry data (0 when empty)
//   count         entries held, 0..DEPTH
//   overflow      sticky: a write was dropped or overwrote the oldest entry
//   halted        FSM is in HALTED
//   state         FSM state: IDLE=00, CAPTURE=01, HALTED=10
//   rd_stamp      head entry cycle stamp (timestamp build only, 0 when empty)

module regwrite_trace_buffer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned WRAP    = 0,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    arm,
    input  logic                    GRegWrite,
    input  logic [ADDR_W-1:0]       WriteAddress,
    input  logic [DATA_W-1:0]       writeDataIn,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    halted,
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    output logic [15:0]             rd_stamp,
`endif
    output logic [1:0]              state
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_CAPTURE = 2'b01;
    localparam logic [1:0] S_HALTED  = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [1:0]         state_nxt;

    logic               arm_accept_c;
    logic               push_req_c;
    logic               pop_req_c;
    logic               full_c;
    logic               mem_we_c;
    logic               rd_adv_c;
    logic               ovf_set_c;
    logic               cnt_inc_c;
    logic               cnt_dec_c;

    // FIFO and watchdog control decode
    always_comb begin
        arm_accept_c = 1'b0;
        push_req_c   = 1'b0;
        pop_req_c    = 1'b0;
        full_c       = 1'b0;
        mem_we_c     = 1'b0;
        rd_adv_c     = 1'b0;
        ovf_set_c    = 1'b0;
        cnt_inc_c    = 1'b0;
        cnt_dec_c    = 1'b0;

        arm_accept_c = arm && ((state == S_IDLE) || (state == S_HALTED));
        push_req_c   = (state == S_CAPTURE) && GRegWrite;
        pop_req_c    = rd_en && (count != '0);
        full_c       = (count == CNT_W'(DEPTH));

        // A full-buffer push still writes when a pop frees the slot or when
        // wrapping; in the wrap case write and read pointers coincide, so the
        // oldest entry is overwritten and the read pointer steps past it.
        mem_we_c  = push_req_c && (!full_c || pop_req_c || (WRAP != 0));
        rd_adv_c  = pop_req_c || (push_req_c && full_c && (WRAP != 0));
        ovf_set_c = push_req_c && full_c && !pop_req_c;
        cnt_inc_c = mem_we_c && !rd_adv_c;
        cnt_dec_c = rd_adv_c && !mem_we_c;
    end

    // Capture FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // idle_cnt still holds the pre-edge value, so this cycle is
                // the TIMEOUT-th quiet one when it equals TIMEOUT-1.
                if (!GRegWrite && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (arm) begin
                    state_nxt = S_CAPTURE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers, occupancy, sticky overflow and watchdog counter
    always_ff @(posedge CLK) begin
        if (RST || arm_accept_c) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            idle_cnt <= '0;
        end else begin
            if (mem_we_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_adv_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cnt_inc_c) begin
                count <= count + CNT_W'(1);
            end else if (cnt_dec_c) begin
                count <= count - CNT_W'(1);
            end
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end
            if (push_req_c) begin
                idle_cnt <= '0;
            end else if (state == S_CAPTURE) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates readout
    always_ff @(posedge CLK) begin
        if (!RST && mem_we_c) begin
            mem[wr_ptr] <= '{addr: WriteAddress, data: writeDataIn};
        end
    end

    // First-word-fall-through head presentation, zeroed when empty
    assign head     = mem[rd_ptr];
    assign rd_valid = (count != '0);
    assign rd_addr  = rd_valid ? head.addr : '0;
    assign rd_data  = rd_valid ? head.data : '0;
    assign halted   = (state == S_HALTED);

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    logic [15:0] cyc_cnt;
    logic [15:0] stamp_mem [DEPTH];

    // Free-running cycle counter, restarted by reset and by an accepted arm
    always_ff @(posedge CLK) begin
        if (RST || arm_accept_c) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end

    // Stamp storage, written alongside the entry
    always_ff @(posedge CLK) begin
        if (!RST && mem_we_c) begin
            stamp_mem[wr_ptr] <= cyc_cnt;
        end
    end

    assign rd_stamp = rd_valid ? stamp_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Self-checking bench for regwrite_trace_buffer: two instances (drop and
// overwrite policies, DEPTH=4, TIMEOUT=5) share one stimulus stream and are
// compared every cycle against a queue-based reference model, with directed
// sequences for the capture, full, watchdog, simultaneous and reset cases
// followed by randomized traffic.

module tb_regwrite_trace_buffer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 5;

    typedef logic [35:0] ent_t;   // {stamp[15:0], addr[3:0], data[15:0]}

    logic        CLK;
    logic        RST;
    logic        arm;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        rd_en;

    logic        rv   [2];
    logic [3:0]  ra   [2];
    logic [15:0] rdd  [2];
    logic [2:0]  cnt  [2];
    logic        ovf  [2];
    logic        hlt  [2];
    logic [1:0]  st   [2];
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    logic [15:0] rs   [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        regwrite_trace_buffer #(
            .DATA_W (16),
            .ADDR_W (4),
            .DEPTH  (DEPTH),
            .WRAP   (g),
            .TIMEOUT(TIMEOUT)
        ) dut (
            .CLK         (CLK),
            .RST         (RST),
            .arm         (arm),
            .GRegWrite   (we),
            .WriteAddress(waddr),
            .writeDataIn (wdata),
            .rd_en       (rd_en),
            .rd_valid    (rv[g]),
            .rd_addr     (ra[g]),
            .rd_data     (rdd[g]),
            .count       (cnt[g]),
            .overflow    (ovf[g]),
            .halted      (hlt[g]),
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
            .rd_stamp    (rs[g]),
`endif
            .state       (st[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int   m_st   [2];
    int   m_idle [2];
    int   m_cyc  [2];
    bit   m_ovf  [2];
    ent_t mq0 [$];
    ent_t mq1 [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one instance of the model by one clock, using the current inputs
    task automatic model_step(input int w);
        ent_t q [$];
        bit   do_pop;
        ent_t e;
        if (w == 0) q = mq0; else q = mq1;
        if (RST) begin
            q.delete();
            m_ovf[w]  = 0;
            m_st[w]   = 0;
            m_idle[w] = 0;
            m_cyc[w]  = 0;
        end else if (m_st[w] != 1 && arm) begin
            q.delete();
            m_ovf[w]  = 0;
            m_idle[w] = 0;
            m_st[w]   = 1;
            m_cyc[w]  = 0;
        end else begin
            do_pop = rd_en && (q.size() > 0);
            e = {16'(m_cyc[w]), waddr, wdata};
            if (m_st[w] == 1 && we) begin
                m_idle[w] = 0;
                if (q.size() == DEPTH && !do_pop) begin
                    m_ovf[w] = 1;
                    if (w == 1) begin
                        void'(q.pop_front());
                        q.push_back(e);
                    end
                end else begin
                    if (do_pop) void'(q.pop_front());
                    q.push_back(e);
                end
            end else begin
                if (do_pop) void'(q.pop_front());
                if (m_st[w] == 1) begin
                    m_idle[w]++;
                    if (m_idle[w] == TIMEOUT) m_st[w] = 2;
                end
            end
            m_cyc[w] = (m_cyc[w] + 1) % 65536;
        end
        if (w == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic check_all();
        ent_t q [$];
        ent_t h;
        for (int w = 0; w < 2; w++) begin
            if (w == 0) q = mq0; else q = mq1;
            h = (q.size() > 0) ? q[0] : '0;
            check_eq($sformatf("w%0d_state", w), 32'(st[w]), 32'(m_st[w]));
            check_eq($sformatf("w%0d_halted", w), 32'(hlt[w]), 32'(m_st[w] == 2));
            check_eq($sformatf("w%0d_count", w), 32'(cnt[w]), 32'(q.size()));
            check_eq($sformatf("w%0d_rd_valid", w), 32'(rv[w]), 32'(q.size() > 0));
            check_eq($sformatf("w%0d_rd_addr", w), 32'(ra[w]), 32'(h[19:16]));
            check_eq($sformatf("w%0d_rd_data", w), 32'(rdd[w]), 32'(h[15:0]));
            check_eq($sformatf("w%0d_overflow", w), 32'(ovf[w]), 32'(m_ovf[w]));
`ifdef REGWRITE_TRACE_TIMESTAMP_EN
            check_eq($sformatf("w%0d_rd_stamp", w), 32'(rs[w]), 32'(h[35:20]));
`endif
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic quiet();
        RST = 0; arm = 0; we = 0; rd_en = 0; waddr = '0; wdata = '0;
    endtask

    task automatic restart();
        quiet();
        RST = 1; tick();
        RST = 0; arm = 1; tick();
        arm = 0;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        we = 1; waddr = a; wdata = d; tick();
        we = 0;
    endtask

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
    logic [15:0] stamp_a;
`endif

    initial begin
        quiet();
        for (int w = 0; w < 2; w++) begin
            m_st[w] = 0; m_idle[w] = 0; m_cyc[w] = 0; m_ovf[w] = 0;
        end

        // Reset state
        RST = 1; tick(); tick();
        check_eq("rst_state", 32'(st[0]), 32'd0);
        check_eq("rst_count", 32'(cnt[0]), 32'd0);
        check_eq("rst_rd_valid", 32'(rv[1]), 32'd0);
        RST = 0;

        // Basic capture and FWFT readout
        arm = 1; tick(); arm = 0;
        check_eq("basic_state", 32'(st[0]), 32'd1);
        push(4'd3, 16'h00A5);
        push(4'd7, 16'h1234);
        check_eq("basic_count", 32'(cnt[0]), 32'd2);
        check_eq("basic_head0_addr", 32'(ra[0]), 32'd3);
        check_eq("basic_head0_data", 32'(rdd[0]), 32'h00A5);
        rd_en = 1; tick();
        check_eq("basic_head1_addr", 32'(ra[0]), 32'd7);
        check_eq("basic_head1_data", 32'(rdd[0]), 32'h1234);
        tick(); rd_en = 0;
        check_eq("basic_empty", 32'(rv[0]), 32'd0);

        // Full buffer: drop (instance 0) versus overwrite (instance 1)
        restart();
        for (int i = 1; i <= 6; i++) push(4'(i), 16'(i));
        check_eq("full_count_drop", 32'(cnt[0]), 32'd4);
        check_eq("full_count_wrap", 32'(cnt[1]), 32'd4);
        check_eq("full_ovf_drop", 32'(ovf[0]), 32'd1);
        check_eq("full_ovf_wrap", 32'(ovf[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drop_read%0d", i), 32'(rdd[0]), 32'(i + 1));
            check_eq($sformatf("wrap_read%0d", i), 32'(rdd[1]), 32'(i + 3));
            rd_en = 1; tick();
        end
        rd_en = 0;

        // Fifth quiet cycle in a row trips the watchdog
        tick();
        check_eq("wd_halted", 32'(hlt[0]), 32'd1);
        check_eq("wd_state", 32'(st[0]), 32'd2);
        push(4'd9, 16'hBEEF);
        check_eq("halted_no_capture", 32'(cnt[0]), 32'd0);
        arm = 1; tick(); arm = 0;
        check_eq("rearm_state", 32'(st[1]), 32'd1);
        check_eq("rearm_ovf", 32'(ovf[1]), 32'd0);
        check_eq("rearm_count", 32'(cnt[1]), 32'd0);
        push(4'd2, 16'h0042);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_eq("wd_not_yet", 32'(hlt[0]), 32'd0);
        tick();
        check_eq("wd_halted2", 32'(hlt[0]), 32'd1);
        check_eq("wd_count2", 32'(cnt[0]), 32'd1);

        // Simultaneous push/pop when full, then reset mid-capture
        restart();
        for (int i = 0; i < 4; i++) push(4'(i), 16'(16'h100 + i));
        check_eq("simul_pre_count", 32'(cnt[0]), 32'd4);
        we = 1; rd_en = 1; waddr = 4'hF; wdata = 16'hFACE; tick();
        we = 0; rd_en = 0;
        check_eq("simul_count_drop", 32'(cnt[0]), 32'd4);
        check_eq("simul_count_wrap", 32'(cnt[1]), 32'd4);
        check_eq("simul_no_ovf", 32'(ovf[0]), 32'd0);
        check_eq("simul_head", 32'(rdd[0]), 32'h0101);
        RST = 1; tick(); RST = 0;
        check_eq("midrst_state", 32'(st[0]), 32'd0);
        check_eq("midrst_count", 32'(cnt[1]), 32'd0);
        check_eq("midrst_data", 32'(rdd[1]), 32'd0);

`ifdef REGWRITE_TRACE_TIMESTAMP_EN
        // Stamps of two writes three cycles apart differ by three
        restart();
        push(4'd1, 16'h0011);
        tick(); tick();
        push(4'd2, 16'h0022);
        stamp_a = rs[0];
        rd_en = 1; tick(); rd_en = 0;
        check_eq("stamp_delta", 32'(rs[0] - stamp_a), 32'd3);
`endif

        // Randomized traffic
        quiet();
        for (int i = 0; i < 3000; i++) begin
            RST   = ($urandom_range(0, 99) == 0);
            arm   = ($urandom_range(0, 7) == 0);
            we    = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 25));
            rd_en = ($urandom_range(0, 99) < 40);
            waddr = 4'($urandom);
            wdata = 16'($urandom);
            tick();
        end
        quiet();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
